// File: rtl/servant_clkgate_pkg.sv
// servant_clkgate_pkg
//   Shared types and constants for the clock-enable sequencer.
//   chan_state_e : per-channel FSM state (OFF, WAKE, ON, IDLE).
//   CNT_W        : width of the per-channel wake/idle down-counter.
package servant_clkgate_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } chan_state_e;

endpackage

// File: rtl/servant_clk_gate_ctrl_if.sv
// servant_clk_gate_ctrl_if
//   Request/acknowledge bundle between the two requesters and the sequencer.
//   i_req    [1:0] per-channel level request (bit n = channel n)
//   o_ack    [1:0] per-channel acknowledge, high only while the channel is ON
//   o_clk_en [1:0] per-channel BUFGCE enable
//   o_busy         high while any channel is waking
//   master: requester side, slave: sequencer side.
interface servant_clk_gate_ctrl_if;
  logic [1:0] i_req;
  logic [1:0] o_ack;
  logic [1:0] o_clk_en;
  logic       o_busy;

  modport master (output i_req, input o_ack, input o_clk_en, input o_busy);
  modport slave  (input i_req, output o_ack, output o_clk_en, output o_busy);
endinterface

// File: rtl/servant_clk_gate_chan.sv
// servant_clk_gate_chan
//   One gated-clock channel: OFF -> WAKE -> ON (-> IDLE) FSM with an 8-bit
//   down-counter timing the wake settle and the idle timeout.
//   Build option: SERVANT_CLKGATE_IDLE_EN enables the IDLE state; without it
//   a request drop in ON gates the clock off immediately.
//   Ports:
//     i_clk, i_rst  ungated clock, asynchronous active-high reset
//     i_req         level request from the requester
//     i_grant       wake token offered by the arbiter (used only in OFF)
//     o_held        registered: channel is in WAKE (holds the token)
//     o_ack         registered: channel is in ON
//     o_en          registered: channel is not OFF (BUFGCE enable)
module servant_clk_gate_chan
  import servant_clkgate_pkg::*;
#(
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_grant,
  output logic o_held,
  output logic o_ack,
  output logic o_en
);

  // Both counters run down to zero inclusive, so load N-1 for N cycles.
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255 ||
      IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_cfg
    $error("servant_clk_gate_chan: WAKE_CYCLES/IDLE_CYCLES must be 1..255");
  end

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             ack_q, ack_d;
  logic             en_q, en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (i_req && i_grant) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // Dropping the request aborts the wake; leaving WAKE frees the token.
        if (!i_req) begin
          state_d = ST_OFF;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ON: begin
        if (!i_req) begin
`ifdef SERVANT_CLKGATE_IDLE_EN
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(IDLE_CYCLES - 1);
`else
          state_d = ST_OFF;
`endif
        end
      end
      ST_IDLE: begin
`ifdef SERVANT_CLKGATE_IDLE_EN
        // Clock is still running, so a returning request skips the wake.
        if (i_req) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = ST_OFF;
`endif
      end
      default: state_d = ST_OFF;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    held_d = (state_d == ST_WAKE);
    ack_d  = (state_d == ST_ON);
    en_d   = (state_d != ST_OFF);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
    end
  end

  assign o_held = held_q;
  assign o_ack  = ack_q;
  assign o_en   = en_q;

endmodule

// File: rtl/servant_clk_gate_ctrl.sv
// servant_clk_gate_ctrl
//   Clock-enable sequencer for the two BUFGCE-gated clocks of the clock
//   generator. Two channel FSMs share a single wake token so the gated
//   domains power up one at a time; contention is resolved round-robin.
//   Build option: SERVANT_CLKGATE_IDLE_EN (idle hold-off before gating off).
//   Ports:
//     i_clk  ungated PLL clock
//     i_rst  asynchronous active-high reset
//     bus    slave side of servant_clk_gate_ctrl_if (i_req, o_ack,
//            o_clk_en, o_busy)
module servant_clk_gate_ctrl
  import servant_clkgate_pkg::*;
#(
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16
) (
  input logic                    i_clk,
  input logic                    i_rst,
  servant_clk_gate_ctrl_if.slave bus
);

  logic [1:0] grant;
  logic [1:0] held;
  logic [1:0] ack;
  logic [1:0] en;
  logic [1:0] want;
  logic       ptr_q, ptr_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    // A channel competes for the token only while its clock is off.
    assign want[gi] = bus.i_req[gi] & ~en[gi];

    servant_clk_gate_chan #(
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_req  (bus.i_req[gi]),
      .i_grant(grant[gi]),
      .o_held (held[gi]),
      .o_ack  (ack[gi]),
      .o_en   (en[gi])
    );
  end

  // Token is free only when no channel is in WAKE as of the last edge, so
  // a waiting channel is granted the cycle after the holder leaves WAKE.
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (held == 2'b00) begin
      if (want == 2'b11) begin
        grant[ptr_q] = 1'b1;
      end else begin
        grant = want;
      end
    end
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.o_ack    = ack;
  assign bus.o_clk_en = en;
  assign bus.o_busy   = |held;

endmodule
